// File: rtl/mod_n_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mod_n_counter_pkg
//  Description : Shared types for the mod-N counter sequencing controller.
//                op_e    - command opcodes carried on cmd_op_i
//                state_e - controller FSM states
//  Revision    : 1.0 - initial release
// ============================================================================
package mod_n_counter_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_CLEAR = 2'd1,
        OP_RUN   = 2'd2,
        OP_STEP  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_STEP  = 2'd3
    } state_e;

endpackage : mod_n_counter_pkg
`default_nettype wire

// File: rtl/mod_n_counter_sync.sv
`default_nettype none
// ============================================================================
//  Module      : mod_n_counter_sync
//  Description : Synchronous modulo-N counter with clear and increment
//                strobes. Clear has priority over increment.
//  Ports       : clk_i   - clock, rising edge
//                rst_i   - synchronous active-high reset
//                clear_i - force count to zero at the next edge
//                incr_i  - advance count by one (mod N) at the next edge
//                count_o - current count, 0..N-1
//                wrap_o  - incr_i while count is N-1 (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_n_counter_sync #(
    parameter int N = 5
) (
    input  wire logic                   clk_i,
    input  wire logic                   rst_i,
    input  wire logic                   clear_i,
    input  wire logic                   incr_i,
    output logic [$clog2(N)-1:0]        count_o,
    output logic                        wrap_o
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] c_max_count = CW'(N - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else if (clear_i) begin
            r_count <= '0;
        end else if (incr_i) begin
            r_count <= (r_count == c_max_count) ? '0 : r_count + CW'(1);
        end
    end

    assign count_o = r_count;
    // Aligned with the increment that rolls the count over to zero.
    assign wrap_o  = incr_i & (r_count == c_max_count);

endmodule : mod_n_counter_sync
`default_nettype wire

// File: rtl/mod_n_counter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mod_n_counter_ctrl
//  Description : Sequencing controller owning one mod-N counter. Accepts
//                CLEAR / RUN (prescaled free-run) / STEP (K increments)
//                commands on a valid/ready interface and drives registered
//                clear/increment strobes plus completion status.
//  Ports       : clk_i, rst_i            - clock / sync active-high reset
//                cmd_valid_i/cmd_ready_o - command handshake (ready = IDLE)
//                cmd_op_i, cmd_arg_i     - opcode and period / step count
//                stop_i                  - abort RUN or STEP
//                incr_o, clear_o         - registered counter strobes
//                count_o, wrap_o         - counter value and rollover pulse
//                busy_o, done_o          - not-IDLE flag, completion pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_n_counter_ctrl
    import mod_n_counter_pkg::*;
#(
    parameter int N     = 5,
    parameter int ARG_W = 8
) (
    input  wire logic                   clk_i,
    input  wire logic                   rst_i,
    input  wire logic                   cmd_valid_i,
    output logic                        cmd_ready_o,
    input  wire logic [1:0]             cmd_op_i,
    input  wire logic [ARG_W-1:0]       cmd_arg_i,
    input  wire logic                   stop_i,
    output logic                        incr_o,
    output logic                        clear_o,
    output logic [$clog2(N)-1:0]        count_o,
    output logic                        wrap_o,
    output logic                        busy_o,
    output logic                        done_o
);

    state_e             r_state, w_state_nxt;
    logic [ARG_W-1:0]   r_cnt, w_cnt_nxt;
    logic [ARG_W-1:0]   r_period, w_period_nxt;
    logic               r_incr, w_incr_nxt;
    logic               r_clear, w_clear_nxt;
    logic               r_done, w_done_nxt;
    logic [ARG_W-1:0]   w_arg_period;

    // A RUN period of zero behaves as period one.
    assign w_arg_period = (cmd_arg_i == '0) ? ARG_W'(1) : cmd_arg_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_period <= '0;
            r_incr   <= 1'b0;
            r_clear  <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_period <= w_period_nxt;
            r_incr   <= w_incr_nxt;
            r_clear  <= w_clear_nxt;
            r_done   <= w_done_nxt;
        end
    end

    // All strobes are registered, so this block decides what the *next*
    // cycle shows. In RUN/STEP a cycle with done high is always the final
    // cycle of the command, which lets the stop-abort cycle and the last
    // STEP pulse share one exit path (and makes a late stop harmless).
    //
    // RUN: r_cnt counts cycles remaining until the next increment cycle;
    //      zero means "increment next cycle", then reload period-1.
    // STEP: r_cnt holds the number of pulses still to be issued.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_period_nxt = r_period;
        w_incr_nxt   = 1'b0;
        w_clear_nxt  = 1'b0;
        w_done_nxt   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    case (op_e'(cmd_op_i))
                        OP_CLEAR: begin
                            w_state_nxt = ST_CLEAR;
                            w_clear_nxt = 1'b1;
                            w_done_nxt  = 1'b1;
                        end
                        OP_RUN: begin
                            w_state_nxt  = ST_RUN;
                            w_period_nxt = w_arg_period;
                            w_cnt_nxt    = w_arg_period - ARG_W'(1);
                        end
                        OP_STEP: begin
                            w_state_nxt = ST_STEP;
                            w_cnt_nxt   = cmd_arg_i;
                            w_done_nxt  = (cmd_arg_i == '0);
                        end
                        default: ;  // NOP is consumed with no effect
                    endcase
                end
            end

            ST_CLEAR: begin
                w_state_nxt = ST_IDLE;
            end

            ST_RUN: begin
                if (r_done) begin
                    w_state_nxt = ST_IDLE;
                end else if (stop_i) begin
                    w_done_nxt = 1'b1;
                end else begin
                    w_incr_nxt = (r_cnt == '0);
                    w_cnt_nxt  = (r_cnt == '0) ? r_period - ARG_W'(1)
                                               : r_cnt - ARG_W'(1);
                end
            end

            ST_STEP: begin
                if (r_done) begin
                    w_state_nxt = ST_IDLE;
                end else if (stop_i) begin
                    w_done_nxt = 1'b1;
                end else begin
                    w_incr_nxt = 1'b1;
                    w_cnt_nxt  = r_cnt - ARG_W'(1);
                    w_done_nxt = (r_cnt == ARG_W'(1));
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    mod_n_counter_sync #(
        .N       (N)
    ) u_counter (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (r_clear),
        .incr_i  (r_incr),
        .count_o (count_o),
        .wrap_o  (wrap_o)
    );

    assign cmd_ready_o = (r_state == ST_IDLE);
    assign busy_o      = (r_state != ST_IDLE);
    assign incr_o      = r_incr;
    assign clear_o     = r_clear;
    assign done_o      = r_done;

endmodule : mod_n_counter_ctrl
`default_nettype wire

// File: doc/mod_n_counter_ctrl.md
# mod_n_counter_ctrl

Synchronous sequencing controller for a mod-N counter. It accepts commands over a valid/ready interface: clear, free-run at a programmable prescaled rate, or step a fixed number of increments. It drives the counter's clear and increment strobes and keeps the authoritative count, wrap and completion status for the surrounding logic. It is the single owner of a counter instance; no other logic drives that counter's increment or clear.

## Interface
- `N`, 5: counter modulus, ≥ 2; count width `CW = $clog2(N)`
- `ARG_W`, 8: width of the command argument (prescale period / step count)

- `clk_i` in 1: clock; all logic on rising edge
- `rst_i` in 1: reset, synchronous, active-high
- `cmd_valid_i` in 1: command present
- `cmd_ready_o` out 1: controller can accept; high iff state IDLE
- `cmd_op_i` in 2: 0 NOP, 1 CLEAR, 2 RUN, 3 STEP
- `cmd_arg_i` in ARG_W: RUN period P or STEP count K
- `stop_i` in 1: abort RUN/STEP
- `incr_o` out 1: registered increment strobe to counter
- `clear_o` out 1: registered clear strobe to counter
- `count_o` out CW: current count, 0..N-1
- `wrap_o` out 1: pulse, coincident with the `incr_o` that takes count N-1→0
- `busy_o` out 1: state ≠ IDLE
- `done_o` out 1: one-cycle completion pulse

## Operation
- Accept = `cmd_valid_i & cmd_ready_o` at a rising edge (edge e0). The opcode and argument are captured at e0.
- States: IDLE, CLEAR, RUN, STEP.
- IDLE:
  - `cmd_ready_o`=1; no strobes.
  - An accepted NOP is consumed, stays in IDLE, and produces no `done_o`.
- CLEAR:
  - Lasts exactly one cycle.
  - `clear_o`=1 and `done_o`=1 in that cycle.
  - `count_o`=0 from the next cycle.
  - Then IDLE.
- RUN:
  - P = `cmd_arg_i`; P=0 is treated as 1.
  - The prescaler emits `incr_o` once every P cycles indefinitely.
  - Exit only via `stop_i`.
- STEP:
  - K = `cmd_arg_i`.
  - Emits exactly K `incr_o` pulses on consecutive cycles.
  - `done_o` is coincident with the K-th pulse; then IDLE.
  - K=0: one STEP cycle with no `incr_o` and `done_o`=1, then IDLE.
- Count:
  - `count_o` advances by 1 (mod N) in the cycle after each `incr_o`.
  - `clear_o` forces 0 and has priority; the two strobes are never asserted together by construction.
- `stop_i`:
  - Sampled in RUN or STEP; ignored in IDLE and CLEAR.
  - When sampled high: no `incr_o` in the following cycle, even if one was due.
  - `done_o`=1 for one cycle, then IDLE.
  - Stop in the same cycle as the final STEP pulse: the pulse was already issued, and only one `done_o` is produced.
- Reset:
  - State IDLE, `count_o`=0; `incr_o`, `clear_o`, `wrap_o`, `done_o`, `busy_o` all 0.
  - `cmd_ready_o`=1 after the reset edge; commands are ignored while `rst_i` is high.
  - Reset mid-RUN or mid-STEP aborts with no `done_o`.

## Timing
- CLEAR accepted at e0: `clear_o`/`done_o` high in cycle e0..e0+1; `count_o`=0 and `cmd_ready_o`=1 after e0+1.
- RUN accepted at e0: `incr_o` high in cycles starting at e0+P, e0+2P, …
- STEP accepted at e0: `incr_o` high in cycles starting at e0+1 … e0+K; `cmd_ready_o` high again at e0+K+1.
- `stop_i` high in the cycle before edge s: `done_o` high in cycle s..s+1; `cmd_ready_o` high at s+1.
- `wrap_o` is combinational from `incr_o` and `count_o==N-1`, so it is aligned with `incr_o`.
- Throughput: one command per (command duration + 0) cycles; back-to-back accepts are legal on the first IDLE cycle.

## Structure
- Package `mod_n_counter_pkg`:
  - `op_e` enum (NOP/CLEAR/RUN/STEP, 2 bits).
  - `state_e` enum (IDLE/CLEAR/RUN/STEP).
- Sub-module `mod_n_counter_sync`:
  - Parameters: N.
  - Ports: `clk_i`, `rst_i`, `clear_i`, `incr_i`, `count_o`, `wrap_o`.
  - Synchronous counter; it is the instance the controller owns and sources `count_o`/`wrap_o` from.
- The controller holds the FSM, the ARG_W-bit prescaler/step down-counter, and the output registers.

## Test plan
- Reset, then STEP K=7 with N=5 → 7 consecutive `incr_o` pulses, one `wrap_o` (on the 5th pulse), `count_o`=2, `done_o` with the 7th pulse.
- RUN P=3 from count 0, `stop_i` after 10 cycles → `incr_o` at cycles 3, 6, 9 only, `count_o`=3, a single `done_o`, then `cmd_ready_o`=1.
- CLEAR at count 4 → one-cycle `clear_o` and `done_o`, then `count_o`=0, no `wrap_o`.
- Boundaries: STEP K=0 → `done_o` with no `incr_o`. RUN P=0 → `incr_o` every cycle. `cmd_valid_i` held high while busy → no accept until IDLE.
- `stop_i` coincident with the final STEP pulse → K increments, exactly one `done_o`.
- `rst_i` asserted mid-RUN at count 3 → `count_o`=0 and all strobes 0 next cycle, no `done_o`, `cmd_ready_o`=1 after release.
